ycr_tcm_mbank: RTL and testbench

- Parametrised multi-bank Tightly-Coupled Memory controller; successor to the fixed two-bank dual-port TCM.
- Serves the core IMEM (read-only) and DMEM (read/write) request ports from NUM_BANKS single-port (1RW) SRAM macros.
- Adds bank-conflict arbitration with an IMEM starvation guard, parametrised bank count and depth, and optional address/alignment error reporting.
- Sits between the core memory router and the SRAM macros.

---
 rtl/ycr_tcm_mbank.sv | 205 ++++++++++++++++++++
 tb/tb_ycr_tcm_mbank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr_tcm_mbank.sv
// Multi-bank TCM controller: IMEM (read) and DMEM (read/write) ports over NUM_BANKS 1RW SRAMs.
// Optional out-of-range / misalignment reporting is enabled with YCR_TCM_ERR_EN.
module ycr_tcm_mbank #(
  parameter int          NUM_BANKS  = 4,
  parameter int          BANK_AW    = 9,
  parameter int          STARVE_LIM = 4,
  parameter logic [31:0] TCM_BASE   = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           imem_req,
  input  logic [31:0]                    imem_addr,
  output logic                           imem_req_ack,
  output logic [31:0]                    imem_rdata,
  output logic [1:0]                     imem_resp,
  input  logic                           dmem_req,
  input  logic                           dmem_cmd,
  input  logic [1:0]                     dmem_width,
  input  logic [31:0]                    dmem_addr,
  input  logic [31:0]                    dmem_wdata,
  output logic                           dmem_req_ack,
  output logic [31:0]                    dmem_rdata,
  output logic [1:0]                     dmem_resp,
  output logic                           sram_clk,
  output logic [NUM_BANKS-1:0]           sram_csb,
  output logic [NUM_BANKS-1:0]           sram_web,
  output logic [NUM_BANKS*BANK_AW-1:0]   sram_addr,
  output logic [NUM_BANKS*4-1:0]         sram_wmask,
  output logic [NUM_BANKS*32-1:0]        sram_din,
  input  logic [NUM_BANKS*32-1:0]        sram_dout
);

  localparam int LB     = $clog2(NUM_BANKS);
  localparam int BW     = (LB > 0) ? LB : 1;
  localparam int TCM_AW = BANK_AW + 2 + LB;

  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_OK     = 2'b01;
  localparam logic [1:0] RESP_ER     = 2'b10;
  localparam logic [1:0] W_BYTE      = 2'b00;
  localparam logic [1:0] W_HWORD     = 2'b01;

  function automatic logic [BW-1:0] bank_of(input logic [31:0] a);
    logic [BW-1:0] b;
    b = a[BANK_AW+2 +: BW];
    if (NUM_BANKS == 1) b = '0;
    return b;
  endfunction

  function automatic logic [3:0] wr_mask(input logic [1:0] w, input logic [1:0] off);
    case (w)
      W_BYTE:  return 4'b0001 << off;
      W_HWORD: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [1:0] w, input logic [31:0] d);
    case (w)
      W_BYTE:  return {4{d[7:0]}};
      W_HWORD: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  logic                i_dec, d_dec, i_err, d_err, conflict, starve_win, i_grant, d_grant;
  logic [BW-1:0]       i_bank, d_bank;
  logic [3:0]          starve_d, starve_q;
  logic                i_ack_d, i_ack_q, d_ack_d, d_ack_q;
  logic [1:0]          i_resp_d, i_resp_q, d_resp_d, d_resp_q;
  logic                i_err_d, i_err_q, d_err_d, d_err_q;
  logic [BW-1:0]       i_bank_d, i_bank_q, d_bank_d, d_bank_q;
  logic [1:0]          d_off_d, d_off_q;
  logic [NUM_BANKS-1:0] csb_d, csb_q, web_d, web_q;
  logic [NUM_BANKS-1:0][BANK_AW-1:0] addr_d, addr_q;
  logic [NUM_BANKS-1:0][3:0]         wmask_d, wmask_q;
  logic [NUM_BANKS-1:0][31:0]        din_d, din_q;
  logic [NUM_BANKS-1:0][31:0]        dout_w;
  logic                unused_bits;

  assign i_bank = bank_of(imem_addr);
  assign d_bank = bank_of(dmem_addr);

`ifdef YCR_TCM_ERR_EN
  assign i_err = (imem_addr[31:TCM_AW] != TCM_BASE[31:TCM_AW]);
  assign d_err = (dmem_addr[31:TCM_AW] != TCM_BASE[31:TCM_AW])
               | ((dmem_width == W_HWORD) & dmem_addr[0])
               | ((dmem_width == 2'b10) & (dmem_addr[1:0] != 2'b00));
  assign unused_bits = ^{imem_addr[1:0]};
`else
  assign i_err = 1'b0;
  assign d_err = 1'b0;
  // Upper address bits are ignored: the TCM aliases across the address space.
  assign unused_bits = ^{imem_addr[1:0], imem_addr[31:TCM_AW], dmem_addr[31:TCM_AW],
                         TCM_BASE[31:TCM_AW]};
`endif

  // Decide-cycle arbitration; errored requests never contend for a bank
  always_comb begin
    i_dec      = imem_req & ~i_ack_q;
    d_dec      = dmem_req & ~d_ack_q;
    conflict   = i_dec & d_dec & ~i_err & ~d_err & (i_bank == d_bank);
    starve_win = conflict & (starve_q == 4'(STARVE_LIM));
    i_grant    = i_dec & (~conflict | starve_win);
    d_grant    = d_dec & (~conflict | ~starve_win);

    starve_d = starve_q;
    if (i_grant)       starve_d = '0;
    else if (conflict) starve_d = starve_q + 4'd1;

    i_ack_d  = i_grant;
    d_ack_d  = d_grant;
    i_resp_d = RESP_NOTRDY;
    d_resp_d = RESP_NOTRDY;
    if (i_ack_q) i_resp_d = i_err_q ? RESP_ER : RESP_OK;
    if (d_ack_q) d_resp_d = d_err_q ? RESP_ER : RESP_OK;

    i_err_d  = i_err_q;
    i_bank_d = i_bank_q;
    d_err_d  = d_err_q;
    d_bank_d = d_bank_q;
    d_off_d  = d_off_q;
    if (i_grant) begin
      i_err_d  = i_err;
      i_bank_d = i_bank;
    end
    if (d_grant) begin
      d_err_d  = d_err;
      d_bank_d = d_bank;
      d_off_d  = dmem_addr[1:0];
    end
  end

  // Bank drive registered at grant, so the access lands in the ack cycle
  always_comb begin
    csb_d   = '1;
    web_d   = '1;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    din_d   = din_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (d_grant & ~d_err & (d_bank == BW'(b))) begin
        csb_d[b]   = 1'b0;
        web_d[b]   = ~dmem_cmd;
        addr_d[b]  = dmem_addr[BANK_AW+1:2];
        wmask_d[b] = wr_mask(dmem_width, dmem_addr[1:0]);
        din_d[b]   = wr_data(dmem_width, dmem_wdata);
      end else if (i_grant & ~i_err & (i_bank == BW'(b))) begin
        csb_d[b]   = 1'b0;
        addr_d[b]  = imem_addr[BANK_AW+1:2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      i_resp_q <= RESP_NOTRDY;
      d_resp_q <= RESP_NOTRDY;
      i_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
      i_bank_q <= '0;
      d_bank_q <= '0;
      d_off_q  <= '0;
      csb_q    <= '1;
      web_q    <= '1;
    end else begin
      starve_q <= starve_d;
      i_ack_q  <= i_ack_d;
      d_ack_q  <= d_ack_d;
      i_resp_q <= i_resp_d;
      d_resp_q <= d_resp_d;
      i_err_q  <= i_err_d;
      d_err_q  <= d_err_d;
      i_bank_q <= i_bank_d;
      d_bank_q <= d_bank_d;
      d_off_q  <= d_off_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wmask_q <= wmask_d;
    din_q   <= din_d;
  end

  assign dout_w       = sram_dout;
  assign sram_clk     = clk;
  assign sram_csb     = csb_q;
  assign sram_web     = web_q;
  assign sram_addr    = addr_q;
  assign sram_wmask   = wmask_q;
  assign sram_din     = din_q;
  assign imem_req_ack = i_ack_q;
  assign dmem_req_ack = d_ack_q;
  assign imem_resp    = i_resp_q;
  assign dmem_resp    = d_resp_q;
  assign imem_rdata   = i_err_q ? '0 : dout_w[i_bank_q];
  assign dmem_rdata   = d_err_q ? '0 : (dout_w[d_bank_q] >> {d_off_q, 3'b000});

endmodule

// File: tb/tb_ycr_tcm_mbank.sv
// Directed bench for ycr_tcm_mbank with a behavioural SRAM and a response scoreboard.
// Runs in either build (YCR_TCM_ERR_EN defined or not).
module tb_ycr_tcm_mbank;
  localparam int NB = 4;
  localparam int AW = 9;
  localparam logic [1:0] OK = 2'b01, ER = 2'b10;
  localparam logic [1:0] WB = 2'b00, WH = 2'b01, WW = 2'b10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, imem_req_ack, dmem_req, dmem_cmd, dmem_req_ack, sram_clk;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0] imem_resp, dmem_resp, dmem_width;
  logic [NB-1:0] sram_csb, sram_web;
  logic [NB*AW-1:0] sram_addr;
  logic [NB*4-1:0] sram_wmask;
  logic [NB*32-1:0] sram_din, sram_dout;

  always #5 clk = ~clk;

  ycr_tcm_mbank #(.NUM_BANKS(NB), .BANK_AW(AW), .STARVE_LIM(4), .TCM_BASE(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ack(imem_req_ack),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp),
    .sram_clk(sram_clk), .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Behavioural 1RW SRAM banks: read data appears one cycle after the access
  logic [31:0] mem [NB][1<<AW];
  always @(posedge sram_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!sram_csb[b]) begin
        sram_dout[b*32 +: 32] <= mem[b][sram_addr[b*AW +: AW]];
        if (!sram_web[b])
          for (int k = 0; k < 4; k++)
            if (sram_wmask[b*4+k]) mem[b][sram_addr[b*AW +: AW]][k*8 +: 8] = sram_din[b*32+k*8 +: 8];
      end
    end
  end

  int n_cmp = 0, n_err = 0;
  typedef struct packed { logic chk; logic [1:0] resp; logic [31:0] data; } exp_t;
  exp_t iq[$], dq[$];

  function automatic logic [31:0] pat(input int b, input int w);
    return 32'hC0DE_0000 ^ 32'(b << 12) ^ 32'(w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e_d, e_i;
    if (dmem_resp !== 2'b00) begin
      if (dq.size() == 0) check("d_unexpected_resp", 32'(dmem_resp), 32'h0);
      else begin
        e_d = dq.pop_front();
        check("d_resp", 32'(dmem_resp), 32'(e_d.resp));
        if (e_d.chk) check("d_rdata", dmem_rdata, e_d.data);
      end
    end
    if (imem_resp !== 2'b00) begin
      if (iq.size() == 0) check("i_unexpected_resp", 32'(imem_resp), 32'h0);
      else begin
        e_i = iq.pop_front();
        check("i_resp", 32'(imem_resp), 32'(e_i.resp));
        if (e_i.chk) check("i_rdata", imem_rdata, e_i.data);
      end
    end
  end

  task automatic d_access(input logic cmd, input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd,
                          input logic chk, input logic [31:0] ed, input logic [1:0] er,
                          output logic [3:0] o_csb, output logic [3:0] o_web,
                          output logic [15:0] o_mask, output logic [127:0] o_din, output int o_wait);
    dmem_req = 1'b1; dmem_cmd = cmd; dmem_width = w; dmem_addr = a; dmem_wdata = wd;
    dq.push_back('{chk, er, ed});
    o_wait = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (dmem_req_ack) begin o_wait = n; break; end
    end
    check("d_ack_timeout", 32'(o_wait >= 0), 32'h1);
    o_csb = sram_csb; o_web = sram_web; o_mask = sram_wmask; o_din = sram_din;
    dmem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic i_access(input logic [31:0] a, input logic [31:0] ed,
                          output logic [3:0] o_csb, output int o_wait);
    imem_req = 1'b1; imem_addr = a;
    iq.push_back('{1'b1, OK, ed});
    o_wait = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (imem_req_ack) begin o_wait = n; break; end
    end
    check("i_ack_timeout", 32'(o_wait >= 0), 32'h1);
    o_csb = sram_csb;
    imem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c1, w1, ic;
    logic [15:0] m1;
    logic [127:0] dn1;
    int t1, it;
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < (1 << AW); w++) mem[b][w] = pat(b, w);
    imem_req = 0; imem_addr = 0; dmem_req = 0; dmem_cmd = 0; dmem_width = WW;
    dmem_addr = 0; dmem_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_ack", 32'(imem_req_ack), 32'h0);
    check("rst_d_ack", 32'(dmem_req_ack), 32'h0);
    check("rst_i_resp", 32'(imem_resp), 32'h0);
    check("rst_d_resp", 32'(dmem_resp), 32'h0);
    check("rst_csb", 32'(sram_csb), 32'hF);
    check("rst_web", 32'(sram_web), 32'hF);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // word write then read-back
    d_access(1'b1, WW, 32'h004, 32'hDEADBEEF, 1'b0, 32'h0, OK, c1, w1, m1, dn1, t1);
    check("wr_latency", 32'(t1), 32'h0);
    check("wr_csb", 32'(c1), 32'hE);
    check("wr_web", 32'(w1), 32'hE);
    check("wr_mask", 32'(m1[3:0]), 32'hF);
    check("wr_din", dn1[31:0], 32'hDEADBEEF);
    d_access(1'b0, WW, 32'h004, 32'h0, 1'b1, 32'hDEADBEEF, OK, c1, w1, m1, dn1, t1);
    check("rd_latency", 32'(t1), 32'h0);
    check("rd_csb", 32'(c1), 32'hE);
    check("rd_web", 32'(w1), 32'hF);

    // byte and halfword formatting
    d_access(1'b1, WB, 32'h007, 32'h0000005A, 1'b0, 32'h0, OK, c1, w1, m1, dn1, t1);
    check("bw_mask", 32'(m1[3:0]), 32'h8);
    check("bw_din", dn1[31:0], 32'h5A5A5A5A);
    d_access(1'b0, WW, 32'h004, 32'h0, 1'b1, 32'h5AADBEEF, OK, c1, w1, m1, dn1, t1);
    d_access(1'b0, WB, 32'h007, 32'h0, 1'b1, 32'h0000005A, OK, c1, w1, m1, dn1, t1);
    d_access(1'b1, WH, 32'h00A, 32'h00001234, 1'b0, 32'h0, OK, c1, w1, m1, dn1, t1);
    check("hw_mask", 32'(m1[3:0]), 32'hC);
    check("hw_din", dn1[31:0], 32'h12341234);
    d_access(1'b0, WW, 32'h008, 32'h0, 1'b1, 32'h12340002, OK, c1, w1, m1, dn1, t1);

    // parallel access to different banks
    fork
      i_access(32'h000, pat(0, 0), ic, it);
      d_access(1'b0, WW, 32'h800, 32'h0, 1'b1, pat(1, 0), OK, c1, w1, m1, dn1, t1);
    join
    check("par_i_wait", 32'(it), 32'h0);
    check("par_d_wait", 32'(t1), 32'h0);
    check("par_csb", 32'(ic), 32'hC);

    // same-bank conflicts: DMEM wins until IMEM has lost STARVE_LIM times
    for (int k = 0; k < 5; k++) begin
      dmem_req = 1; dmem_cmd = 0; dmem_width = WW; dmem_addr = 32'h010;
      imem_req = 1; imem_addr = 32'h020;
      @(posedge clk); #1;
      if (k < 4) begin
        check($sformatf("starve_d_ack%0d", k), 32'(dmem_req_ack), 32'h1);
        check($sformatf("starve_i_ack%0d", k), 32'(imem_req_ack), 32'h0);
        dq.push_back('{1'b1, OK, pat(0, 4)});
        dmem_req = 0; imem_req = 0;
        @(posedge clk); #1;
      end else begin
        check("starve_i_wins", 32'(imem_req_ack), 32'h1);
        check("starve_d_loses", 32'(dmem_req_ack), 32'h0);
        iq.push_back('{1'b1, OK, pat(0, 8)});
        imem_req = 0;
        @(posedge clk); #1;
        check("starve_d_after", 32'(dmem_req_ack), 32'h1);
        dq.push_back('{1'b1, OK, pat(0, 4)});
        dmem_req = 0;
        @(posedge clk); #1;
      end
    end
    dmem_req = 1; imem_req = 1;
    @(posedge clk); #1;
    check("starve_clr_d_ack", 32'(dmem_req_ack), 32'h1);
    check("starve_clr_i_ack", 32'(imem_req_ack), 32'h0);
    dq.push_back('{1'b1, OK, pat(0, 4)});
    dmem_req = 0; imem_req = 0;
    repeat (3) @(posedge clk);
    #1;

    // asynchronous reset in the ack cycle
    dmem_req = 1; dmem_cmd = 0; dmem_width = WW; dmem_addr = 32'h004;
    @(posedge clk); #1;
    check("arst_pre_ack", 32'(dmem_req_ack), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_csb", 32'(sram_csb), 32'hF);
    check("arst_ack", 32'(dmem_req_ack), 32'h0);
    check("arst_resp", 32'(dmem_resp), 32'h0);
    dmem_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("arst_no_stale%0d", k), 32'(dmem_resp), 32'h0);
    end
    @(posedge clk); #1;

    // out-of-range and misaligned requests
`ifdef YCR_TCM_ERR_EN
    d_access(1'b0, WW, 32'h0001_0000, 32'h0, 1'b1, 32'h0, ER, c1, w1, m1, dn1, t1);
    check("err_range_csb", 32'(c1), 32'hF);
    d_access(1'b0, WH, 32'h003, 32'h0, 1'b1, 32'h0, ER, c1, w1, m1, dn1, t1);
    check("err_align_csb", 32'(c1), 32'hF);
`else
    d_access(1'b0, WW, 32'h0001_0000, 32'h0, 1'b1, pat(0, 0), OK, c1, w1, m1, dn1, t1);
    check("alias_csb", 32'(c1), 32'hE);
    d_access(1'b0, WH, 32'h003, 32'h0, 1'b1, 32'h000000C0, OK, c1, w1, m1, dn1, t1);
    check("misalign_csb", 32'(c1), 32'hE);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("dq_drained", 32'(dq.size()), 32'h0);
    check("iq_drained", 32'(iq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
